// File: rtl/segment_wave_player.sv
// Segment waveform player: takes one segment instruction, reads the referenced
// waveform words (all repeats) from memory one request at a time, buffers them in
// a small FIFO, and streams them out over a valid/ready port.
//
// state  | meaning
// IDLE   | waiting for a segment instruction
// FETCH  | issuing reads and pushing returned words into the FIFO
// DRAIN  | all words fetched, waiting for the FIFO to empty
// DONE   | segment emitted; generate_done fires on the following cycle
module segment_wave_player #(
   parameter int ADDR_W     = 33,
   parameter int DATA_W     = 128,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [127:0]      segment_instruc,
   input  logic              segment_instruc_valid,
   output logic              generate_done,
   output logic              busy,
   output logic              instr_err,
   output logic [ADDR_W-1:0] mem_rd_addr,
   output logic              mem_rd_valid,
   input  logic [DATA_W-1:0] mem_rd_data,
   input  logic              mem_rd_ack,
   output logic [DATA_W-1:0] wave_data,
   output logic              wave_valid,
   input  logic              wave_ready
);

   localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
   localparam logic [2:0]  OP_SEG  = 3'b101;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d, cur_q, cur_d;
   logic [15:0]         len_q, len_d, rep_q, rep_d;
   logic [15:0]         word_cnt_q, word_cnt_d, rep_cnt_q, rep_cnt_d;
   logic                pending_q, pending_d;
   logic                busy_q, busy_d, err_q, err_d, done_q, done_d;

   logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [PW:0]         count_q;
   logic                push, pop;

   logic [2:0]          in_op;
   logic [ADDR_W-1:0]   in_base;
   logic [15:0]         in_len, in_rep;
   logic                accept, reject;
   logic                instr_unused;

   assign in_op   = segment_instruc[127:125];
   assign in_base = segment_instruc[64 +: ADDR_W];
   assign in_len  = segment_instruc[47:32];
   assign in_rep  = segment_instruc[15:0];
   assign instr_unused = ^{segment_instruc[124:64+ADDR_W], segment_instruc[63:48],
                           segment_instruc[31:16]};

   // busy_q stays high through the generate_done cycle, so a strobe landing on
   // that cycle is rejected like any other strobe while busy.
   assign accept = segment_instruc_valid & ~busy_q & (in_op == OP_SEG);
   assign reject = segment_instruc_valid & (busy_q | (in_op != OP_SEG));

   assign push = pending_q & mem_rd_ack;
   assign pop  = (count_q != '0) & wave_ready;

   assign generate_done = done_q;
   assign busy          = busy_q;
   assign instr_err     = err_q;
   assign mem_rd_valid  = pending_q;
   assign mem_rd_addr   = cur_q;
   assign wave_valid    = (count_q != '0);
   assign wave_data     = wave_valid ? fifo_mem[rd_ptr_q] : '0;

   // Control state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         cur_q      <= '0;
         len_q      <= '0;
         rep_q      <= '0;
         word_cnt_q <= '0;
         rep_cnt_q  <= '0;
         pending_q  <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         cur_q      <= cur_d;
         len_q      <= len_d;
         rep_q      <= rep_d;
         word_cnt_q <= word_cnt_d;
         rep_cnt_q  <= rep_cnt_d;
         pending_q  <= pending_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         done_q     <= done_d;
      end
   end

   // Next-state logic: instruction accept, read issue/completion, pass/repeat walk.
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      cur_d      = cur_q;
      len_d      = len_q;
      rep_d      = rep_q;
      word_cnt_d = word_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      pending_d  = pending_q;
      busy_d     = busy_q;
      err_d      = err_q | reject;
      done_d     = (state_q == S_DONE);
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               base_d     = in_base;
               cur_d      = in_base;
               len_d      = in_len;
               rep_d      = (in_rep == 16'd0) ? 16'd1 : in_rep;
               word_cnt_d = '0;
               rep_cnt_d  = '0;
               busy_d     = 1'b1;
               state_d    = (in_len == 16'd0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            if (push) begin
               pending_d = 1'b0;
               if (word_cnt_q == len_q - 16'd1) begin
                  word_cnt_d = '0;
                  cur_d      = base_q;
                  rep_cnt_d  = rep_cnt_q + 16'd1;
                  if (rep_cnt_q == rep_q - 16'd1) begin
                     state_d = S_DRAIN;
                  end
               end else begin
                  word_cnt_d = word_cnt_q + 16'd1;
                  cur_d      = cur_q + ADDR_W'(16);
               end
            end else if (!pending_q && (count_q < DEPTH_C)) begin
               // With no read in flight, a free slot now stays free for its data.
               pending_d = 1'b1;
            end
         end
         S_DRAIN: begin
            if (count_q == '0) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (done_q) begin
         busy_d = 1'b0;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
      end
   end

   // FIFO storage; contents are don't-care while the slot is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= mem_rd_data;
      end
   end

endmodule
